// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: per-frame BCD snapshot, prescaled digit scan,
// BCD decode with leading-zero blanking, registered anode/segment outputs.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic                    frame_done
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pre_q;
    logic [IW-1:0]           idx_q;
    logic [4*NUM_DIGITS-1:0] snap_bcd_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic                    frame_done_q;

    // Output registers hold active-high values; pin polarity is applied afterwards.
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    tick;
    logic                    last;
    logic                    lit;
    logic                    any_nz;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              cur_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign tick = (pre_q == PRE_MAX);
    assign last = (idx_q == IDX_MAX);

    // Walk from the most significant digit down; a digit stays blank until a
    // nonzero code has been seen at or above it. Digit 0 is never blanked.
    always_comb begin
        any_nz = 1'b0;
        blank  = '0;
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            any_nz   = any_nz | (snap_bcd_q[4*k +: 4] != 4'd0);
            blank[k] = ~any_nz;
        end
    end

    always_comb begin
        an_d      = '0;
        seg_d     = '0;
        dp_d      = 1'b0;
        cur_digit = snap_bcd_q[4*idx_q +: 4];
        lit       = en & ~blank[idx_q];
        if (lit) begin
            an_d[idx_q] = 1'b1;
            seg_d       = decode(cur_digit);
            dp_d        = snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q        <= '0;
            idx_q        <= '0;
            snap_bcd_q   <= '0;
            snap_dp_q    <= '0;
            frame_done_q <= 1'b0;
            an_q         <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                idx_q <= last ? '0 : idx_q + 1'b1;
            end
            if (tick && last) begin
                snap_bcd_q <= bcd;
                snap_dp_q  <= dp;
            end
            frame_done_q <= tick & last;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = {NUM_DIGITS{AN_ACTIVE_LOW}} ^ an_q;
    assign seg        = {7{SEG_ACTIVE_LOW}} ^ seg_q;
    assign dp_out     = SEG_ACTIVE_LOW ^ dp_q;
    assign frame_done = frame_done_q;

endmodule
